// File: rtl/lcd_spi_pkg.sv
// Shared types for the LCD SPI transmitter: FSM states, request control flags
// and the bit-counter width helper.
package lcd_spi_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;

    // Control half of a request entry; the top wraps this with a DATA_W payload.
    typedef struct packed {
        logic rel;
        logic dc;
        logic wide;
    } req_ctl_t;

    localparam int CTL_W = $bits(req_ctl_t);

    // Width of a counter that must hold the value dw (bits per transfer).
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/lcd_spi_sync_fifo.sv
// Generic single-clock FIFO with full/empty flags and an occupancy count.
module lcd_spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_spi_master.sv
// FIFO-buffered SPI transmitter for an ILI9341-class LCD (8-bit or DATA_W-bit words).
// Optional receive path enabled by defining LCD_SPI_RX_EN.
module lcd_spi_master
    import lcd_spi_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_wide,
    input  logic                        in_dc,
    input  logic                        in_release,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        DCX,
    output logic                        CSX,
    output logic                        SDO,
    output logic                        SCK
`ifdef LCD_SPI_RX_EN
    ,
    input  logic                        SDI,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid
`endif
);
    localparam int BW = cnt_w(DATA_W);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef struct packed {
        req_ctl_t          ctl;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              wr_req, head, cur;
    logic              full, empty, pop, phase_end;
    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bits;
    logic [DW-1:0]     div;

    assign wr_req   = {in_release, in_dc, in_wide, in_data};
    assign in_ready = !full;

    lcd_spi_sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !full),
        .wdata (wr_req),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign phase_end = (div == DW'(CLK_DIV - 1));

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                state_nx = LOAD;
            end
            LOAD: state_nx = cur.ctl.rel ? IDLE : LOW;
            LOW:  if (phase_end) state_nx = HIGH;
            HIGH: if (phase_end) state_nx = (bits == BW'(1)) ? DONE : LOW;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            CSX   <= 1'b1;
            DCX   <= 1'b0;
            shreg <= '0;
            bits  <= '0;
            div   <= '0;
            cur   <= '0;
        end else begin
            state <= state_nx;
            if (pop) cur <= head;
            case (state)
                LOAD: begin
                    CSX <= cur.ctl.rel;
                    DCX <= cur.ctl.dc;
                    div <= '0;
                    if (!cur.ctl.rel) begin
                        // Narrow words are left-aligned so data[7] leaves first.
                        shreg <= cur.ctl.wide ? cur.data : (DATA_W'(cur.data[7:0]) << (DATA_W - 8));
                        bits  <= cur.ctl.wide ? BW'(DATA_W) : BW'(8);
                    end
                end
                LOW, HIGH: begin
                    div <= phase_end ? '0 : div + 1'b1;
                    if (state == HIGH && phase_end) begin
                        shreg <= shreg << 1;
                        bits  <= bits - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SCK  = (state == HIGH);
    assign SDO  = (state == LOW || state == HIGH) && shreg[DATA_W-1];
    assign busy = !empty || (state != IDLE);

`ifdef LCD_SPI_RX_EN
    logic [DATA_W-1:0] rx_sh;

    // SDI is captured on the first clk of HIGH, i.e. at the SCK rising edge.
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) rx_sh <= '0;
        else if (state == HIGH && div == '0) rx_sh <= {rx_sh[DATA_W-2:0], SDI};
    end

    assign rx_data  = rx_sh;
    assign rx_valid = (state == DONE);
`endif

endmodule

// File: tb/tb_lcd_spi_master.sv
// Directed bench for lcd_spi_master: one instance at CLK_DIV=1, one at CLK_DIV=3.
module tb_lcd_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // CLK_DIV=1 instance
    logic        in_valid = 1'b0, in_wide = 1'b0, in_dc = 1'b0, in_release = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, busy, DCX, CSX, SDO, SCK;
    logic [3:0]  fifo_count;

    // CLK_DIV=3 instance
    logic        v3 = 1'b0;
    logic [15:0] d3 = '0;
    logic        r3, b3, dcx3, csx3, sdo3, sck3;
    logic [3:0]  c3;

`ifdef LCD_SPI_RX_EN
    logic        sdi = 1'b0;
    logic [15:0] rx_data, rx3;
    logic        rx_valid, rxv3;
`endif

    lcd_spi_master #(.DATA_W(16), .FIFO_DEPTH(8), .CLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_wide(in_wide), .in_dc(in_dc), .in_release(in_release), .busy(busy),
        .fifo_count(fifo_count), .DCX(DCX), .CSX(CSX), .SDO(SDO), .SCK(SCK)
`ifdef LCD_SPI_RX_EN
        , .SDI(sdi), .rx_data(rx_data), .rx_valid(rx_valid)
`endif
    );

    lcd_spi_master #(.DATA_W(16), .FIFO_DEPTH(8), .CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3),
        .in_wide(1'b0), .in_dc(1'b1), .in_release(1'b0), .busy(b3),
        .fifo_count(c3), .DCX(dcx3), .CSX(csx3), .SDO(sdo3), .SCK(sck3)
`ifdef LCD_SPI_RX_EN
        , .SDI(1'b0), .rx_data(rx3), .rx_valid(rxv3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller must be at a negedge; accepted at the following posedge.
    task automatic push(input logic r, input logic d, input logic w, input logic [15:0] data);
        in_valid = 1'b1; in_release = r; in_dc = d; in_wide = w; in_data = data;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect nbits SDO values at SCK rises; returns at the first low sample after the last pulse.
    task automatic cap(input int nbits, output logic [15:0] w, output int hmin, output int hmax,
                       output logic dcx_first, output logic tmo);
        int   rises = 0, run = 0, guard = 0;
        logic prev  = 1'b0;
        w = '0; hmin = 1000; hmax = 0; dcx_first = 1'bx; tmo = 1'b1;
        while (guard < 2000) begin
            @(negedge clk);
            guard++;
            if (SCK && !prev) begin
                w = {w[14:0], SDO};
                rises++;
                if (rises == 1) dcx_first = DCX;
            end
            if (SCK) run++;
            else if (prev) begin
                if (run < hmin) hmin = run;
                if (run > hmax) hmax = run;
                run = 0;
                if (rises == nbits) begin tmo = 1'b0; break; end
            end
            prev = SCK;
        end
    endtask

    logic [15:0] w;
    int          hmin, hmax;
    logic        dcf, tmo;
    logic [7:0]  bytes [10];

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst CSX", CSX, 1);
        chk("rst DCX", DCX, 0);
        chk("rst SCK", SCK, 0);
        chk("rst SDO", SDO, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst fifo_count", fifo_count, 0);

        // Command byte 0x2A, cycle-exact start
        push(1'b0, 1'b0, 1'b0, 16'h002A);
        chk("cmd count N", fifo_count, 1);
        chk("cmd busy N", busy, 1);
        @(negedge clk);
        chk("cmd count N+1", fifo_count, 0);
        chk("cmd CSX N+1", CSX, 1);
        @(negedge clk);
        chk("cmd CSX N+2", CSX, 0);
        chk("cmd DCX N+2", DCX, 0);
        chk("cmd SCK N+2", SCK, 0);
        chk("cmd SDO N+2", SDO, 0);
        cap(8, w, hmin, hmax, dcf, tmo);
        chk("cmd timeout", tmo, 0);
        chk("cmd byte", w, 16'h002A);
        chk("cmd high min", hmin, 1);
        chk("cmd high max", hmax, 1);
        chk("cmd busy DONE", busy, 1);
        chk("cmd SDO DONE", SDO, 0);
        @(negedge clk);
        chk("cmd busy after", busy, 0);
        chk("cmd CSX held", CSX, 0);

        // Wide data 0xF81F then release
        push(1'b0, 1'b1, 1'b1, 16'hF81F);
        push(1'b1, 1'b1, 1'b0, 16'h0000);
        cap(16, w, hmin, hmax, dcf, tmo);
        chk("wide timeout", tmo, 0);
        chk("wide word", w, 16'hF81F);
        chk("wide DCX", dcf, 1);
        @(negedge clk);
        chk("rel CSX idle", CSX, 0);
        @(negedge clk);
        chk("rel CSX load", CSX, 0);
        @(negedge clk);
        chk("rel CSX", CSX, 1);
        chk("rel DCX", DCX, 1);
        chk("rel SCK", SCK, 0);
        chk("rel busy", busy, 0);

        // FIFO_DEPTH+2 back-to-back bytes
        for (int i = 0; i < 10; i++) bytes[i] = 8'(i * 37 + 5);
        fork
            begin
                int   pi = 0, guard = 0;
                logic rdy, saw_full = 1'b0, bad = 1'b0;
                in_valid = 1'b1; in_release = 1'b0; in_dc = 1'b1; in_wide = 1'b0;
                in_data = {8'h00, bytes[0]};
                while (pi < 10 && guard < 1000) begin
                    rdy = in_ready;
                    if (fifo_count == 4'd8) begin
                        saw_full = 1'b1;
                        if (rdy) bad = 1'b1;
                    end else if (!rdy) bad = 1'b1;
                    @(negedge clk);
                    guard++;
                    if (rdy) begin
                        pi++;
                        if (pi < 10) in_data = {8'h00, bytes[pi]};
                    end
                end
                in_valid = 1'b0;
                chk("burst all pushed", pi, 10);
                chk("burst saw full", saw_full, 1);
                chk("burst ready rule", bad, 0);
            end
            begin
                logic [15:0] bw;
                int          bmin, bmax;
                logic        bdc, bto;
                for (int i = 0; i < 10; i++) begin
                    cap(8, bw, bmin, bmax, bdc, bto);
                    chk($sformatf("burst byte %0d", i), {bto, bw}, {1'b0, 8'h00, bytes[i]});
                end
            end
        join
        @(negedge clk);
        chk("burst drained busy", busy, 0);
        chk("burst drained count", fifo_count, 0);

        // CLK_DIV=3 instance, byte 0x81
        begin
            int   n = 0, rises = 0, first = -1, hrun = 0, lrun = 0, hbad = 0, lbad = 0;
            logic prev = 1'b0;
            logic [7:0] wb = '0;
            v3 = 1'b1; d3 = 16'h0081;
            @(negedge clk);
            v3 = 1'b0;
            for (int k = 1; k < 200; k++) begin
                @(negedge clk);
                if (!b3) break;
                n++;
                if (sck3 && !prev) begin
                    rises++;
                    wb = {wb[6:0], sdo3};
                    if (rises == 1) first = k;
                    else if (lrun != 3) lbad++;
                    lrun = 0;
                end
                if (sck3) hrun++;
                else begin
                    if (prev) begin
                        if (hrun != 3) hbad++;
                        hrun = 0;
                    end
                    lrun++;
                end
                prev = sck3;
            end
            chk("div3 busy cycles", n, 50);
            chk("div3 first rise", first, 5);
            chk("div3 rises", rises, 8);
            chk("div3 byte", wb, 8'h81);
            chk("div3 high width", hbad, 0);
            chk("div3 low width", lbad, 0);
            chk("div3 CSX held", csx3, 0);
            chk("div3 DCX", dcx3, 1);
        end

        // Reset during bit 4 of a wide transfer
        begin
            int   rises = 0;
            logic prev = 1'b0;
            push(1'b0, 1'b1, 1'b1, 16'h1234);
            push(1'b0, 1'b1, 1'b0, 16'h0055);
            for (int k = 0; k < 200 && rises < 4; k++) begin
                @(negedge clk);
                if (SCK && !prev) rises++;
                prev = SCK;
            end
            chk("abort reached bit4", rises, 4);
            chk("abort count before", fifo_count, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort CSX", CSX, 1);
            chk("abort SCK", SCK, 0);
            chk("abort SDO", SDO, 0);
            chk("abort count", fifo_count, 0);
            chk("abort busy", busy, 0);
            repeat (5) @(negedge clk);
            chk("abort stays idle", {CSX, SCK, busy}, 3'b100);
        end

`ifdef LCD_SPI_RX_EN
        begin
            int   k = 0;
            logic sdo_seen = 1'b0;
            chk("rx rst data", rx_data, 0);
            sdi = 1'b1;
            push(1'b0, 1'b1, 1'b0, 16'h0000);
            while (!rx_valid && k < 200) begin
                @(negedge clk);
                k++;
                if (SDO) sdo_seen = 1'b1;
            end
            chk("rx valid seen", rx_valid, 1);
            chk("rx data", rx_data, 16'h00FF);
            chk("rx SDO low", sdo_seen, 0);
            @(negedge clk);
            chk("rx valid pulse", rx_valid, 0);
            sdi = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
